xs3_to_bcd_seq: RTL and testbench

Sequential Excess-3 to BCD decoder; the receive-side counterpart of the team's BCD to Excess-3 converter. It accepts one 4-bit Excess-3 digit per handshake, most significant digit first, and subtracts 3 from each. It rejects codes outside the Excess-3 range and packs `DIGITS` decoded digits into one BCD word, which it presents downstream with a valid/ack handshake. It sits between a serial Excess-3 source and any consumer of packed BCD, such as display or arithmetic blocks.

---
 rtl/xs3_to_bcd_seq.sv | 108 ++++++++++
 tb/tb_xs3_to_bcd_seq.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/xs3_to_bcd_seq.sv
// Sequential Excess-3 to packed-BCD decoder: one digit per handshake, MSD first,
// DIGITS digits per word, presented downstream with a valid/ack handshake.
module xs3_to_bcd_seq #(
    parameter int unsigned DIGITS = 4
) (
    input  logic                in_clk,
    input  logic                in_rst,
    input  logic                in_valid,
    input  logic [3:0]          in_xs3,
    output logic                out_ready,
    output logic [4*DIGITS-1:0] out_bcd,
    output logic                out_valid,
    input  logic                in_ack,
    output logic                out_err,
    input  logic                in_flush
);

    localparam int unsigned CntW = $clog2(DIGITS + 1);
    localparam int unsigned W    = 4 * DIGITS;
    localparam logic [CntW-1:0] LastCnt = CntW'(DIGITS - 1);

    typedef enum logic [1:0] {
        StCollect,
        StPresent,
        StError
    } state_e;

    state_e          state_q;
    logic [CntW-1:0] count_q;
    logic [W-1:0]    shift_q;
    logic            ready_q;
    logic            valid_q;
    logic            err_q;

    logic       code_ok;
    logic [3:0] digit;

    assign code_ok = (in_xs3 >= 4'h3) && (in_xs3 <= 4'hC);
    assign digit   = in_xs3 - 4'd3;

    // Flags are registered alongside the state so they decode it without input paths.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_q <= StCollect;
            count_q <= '0;
            shift_q <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else if (in_flush) begin
            state_q <= StCollect;
            count_q <= '0;
            shift_q <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StCollect: begin
                    if (in_valid) begin
                        if (code_ok) begin
                            shift_q <= {shift_q[W-5:0], digit};
                            if (count_q == LastCnt) begin
                                count_q <= '0;
                                state_q <= StPresent;
                                ready_q <= 1'b0;
                                valid_q <= 1'b1;
                            end else begin
                                count_q <= count_q + 1'b1;
                            end
                        end else begin
                            // Partial word is kept as-is; only a flush leaves this state.
                            count_q <= '0;
                            state_q <= StError;
                            ready_q <= 1'b0;
                            err_q   <= 1'b1;
                        end
                    end
                end
                StPresent: begin
                    if (in_ack) begin
                        shift_q <= '0;
                        state_q <= StCollect;
                        ready_q <= 1'b1;
                        valid_q <= 1'b0;
                    end
                end
                StError: begin
                    state_q <= StError;
                end
                default: begin
                    state_q <= StCollect;
                    count_q <= '0;
                    shift_q <= '0;
                    ready_q <= 1'b1;
                    valid_q <= 1'b0;
                    err_q   <= 1'b0;
                end
            endcase
        end
    end

    assign out_ready = ready_q;
    assign out_valid = valid_q;
    assign out_err   = err_q;
    assign out_bcd   = shift_q;

endmodule

// File: tb/tb_xs3_to_bcd_seq.sv
// Self-checking bench for xs3_to_bcd_seq: vector table, directed corner cases,
// parameter sweep and a randomized run against an arithmetic reference model.
module tb_xs3_to_bcd_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        v, ack, fl;
    logic [3:0]  x;
    logic        rdy, vld, err;
    logic [15:0] bcd;

    logic        v2, v8;
    logic [3:0]  x2, x8;
    logic        rdy2, vld2, err2, rdy8, vld8, err8;
    logic [7:0]  bcd2;
    logic [31:0] bcd8;
    logic        zero = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    xs3_to_bcd_seq #(.DIGITS(4)) dut (
        .in_clk(clk), .in_rst(rst), .in_valid(v), .in_xs3(x), .out_ready(rdy),
        .out_bcd(bcd), .out_valid(vld), .in_ack(ack), .out_err(err), .in_flush(fl)
    );

    xs3_to_bcd_seq #(.DIGITS(2)) dut2 (
        .in_clk(clk), .in_rst(rst), .in_valid(v2), .in_xs3(x2), .out_ready(rdy2),
        .out_bcd(bcd2), .out_valid(vld2), .in_ack(zero), .out_err(err2), .in_flush(zero)
    );

    xs3_to_bcd_seq #(.DIGITS(8)) dut8 (
        .in_clk(clk), .in_rst(rst), .in_valid(v8), .in_xs3(x8), .out_ready(rdy8),
        .out_bcd(bcd8), .out_valid(vld8), .in_ack(zero), .out_err(err8), .in_flush(zero)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] code);
        v = 1'b1;
        x = code;
        tick();
        v = 1'b0;
    endtask

    // Reference model: word value held as an integer, digits appended arithmetically.
    bit     m_err, m_present;
    int     m_count;
    longint m_word;

    task automatic model_reset();
        m_err = 0; m_present = 0; m_count = 0; m_word = 0;
    endtask

    task automatic model_edge(input bit mv, input int code, input bit mack, input bit mfl);
        if (mfl) begin
            model_reset();
        end else if (m_err) begin
            // only a flush recovers
        end else if (m_present) begin
            if (mack) begin
                m_present = 0;
                m_word = 0;
            end
        end else if (mv) begin
            if (code < 3 || code > 12) begin
                m_err = 1;
                m_count = 0;
            end else begin
                m_word = (m_word * 16 + (code - 3)) % 65536;
                m_count++;
                if (m_count == 4) begin
                    m_present = 1;
                    m_count = 0;
                end
            end
        end
    endtask

    typedef struct {
        logic [15:0] codes;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl[7];

    initial begin
        tbl[0] = '{16'h4567, 16'h1234};
        tbl[1] = '{16'h3C3C, 16'h0909};
        tbl[2] = '{16'hCCCC, 16'h9999};
        tbl[3] = '{16'h89AB, 16'h5678};
        tbl[4] = '{16'h3333, 16'h0000};
        tbl[5] = '{16'h3456, 16'h0123};
        tbl[6] = '{16'hBA98, 16'h8765};

        v = 0; x = 0; ack = 0; fl = 0; v2 = 0; x2 = 0; v8 = 0; x8 = 0;
        rst = 1'b1;
        #2;
        check("reset_ready", {31'd0, rdy}, 32'd1);
        check("reset_valid", {31'd0, vld}, 32'd0);
        check("reset_err", {31'd0, err}, 32'd0);
        check("reset_bcd", {16'd0, bcd}, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Vector table
        for (int i = 0; i < 7; i++) begin
            for (int k = 0; k < 4; k++) begin
                logic [15:0] c;
                c = tbl[i].codes;
                send(c[15-4*k -: 4]);
                if (k == 2) check("tbl_not_yet_valid", {31'd0, vld}, 32'd0);
            end
            check("tbl_valid", {31'd0, vld}, 32'd1);
            check("tbl_ready_low", {31'd0, rdy}, 32'd0);
            check("tbl_bcd", {16'd0, bcd}, {16'd0, tbl[i].exp});
            ack = 1'b1; tick(); ack = 1'b0;
            check("tbl_ack_valid", {31'd0, vld}, 32'd0);
            check("tbl_ack_ready", {31'd0, rdy}, 32'd1);
            check("tbl_ack_clear", {16'd0, bcd}, 32'd0);
        end

        // Basic word held for 10 cycles
        send(4'h4); send(4'h5); send(4'h6); send(4'h7);
        for (int i = 0; i < 10; i++) begin
            check("hold_bcd", {16'd0, bcd}, 32'h1234);
            check("hold_ready", {30'd0, rdy, vld}, 32'd1);
            tick();
        end
        ack = 1'b1; tick(); ack = 1'b0;
        check("hold_ack", {30'd0, rdy, vld}, 32'd2);

        // Extremes, immediate ack, then in_valid held high through PRESENT
        send(4'h3); send(4'hC); send(4'h3); send(4'hC);
        check("b2b_first", {15'd0, vld, bcd}, {15'd0, 1'b1, 16'h0909});
        ack = 1'b1; v = 1'b1; x = 4'hC;
        tick();
        ack = 1'b0;
        check("b2b_ack", {30'd0, rdy, vld}, 32'd2);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) check("b2b_not_early", {31'd0, vld}, 32'd0);
            tick();
        end
        v = 1'b0;
        check("b2b_second", {15'd0, vld, bcd}, {15'd0, 1'b1, 16'h9999});
        ack = 1'b1; tick(); ack = 1'b0;

        // Invalid code
        send(4'h4); send(4'h5); send(4'hD);
        check("inv_flags", {29'd0, err, rdy, vld}, 32'h4);
        ack = 1'b1; tick(); ack = 1'b0;
        check("inv_ack_ignored", {29'd0, err, rdy, vld}, 32'h4);
        send(4'h6);
        check("inv_valid_ignored", {29'd0, err, rdy, vld}, 32'h4);
        fl = 1'b1; tick(); fl = 1'b0;
        check("inv_flush", {13'd0, err, rdy, vld, bcd}, {13'd0, 3'b010, 16'h0});
        send(4'h8); send(4'h9); send(4'hA); send(4'hB);
        check("inv_recover", {13'd0, err, rdy, vld, bcd}, {13'd0, 3'b001, 16'h5678});
        ack = 1'b1; tick(); ack = 1'b0;

        // Flush beats a same-cycle accept
        send(4'h4); send(4'h5); send(4'h6);
        fl = 1'b1; v = 1'b1; x = 4'h7;
        tick();
        fl = 1'b0; v = 1'b0;
        check("flush_prio", {15'd0, rdy, bcd}, {15'd0, 1'b1, 16'h0});
        send(4'h3); send(4'h3); send(4'h3);
        check("flush_count0", {31'd0, vld}, 32'd0);
        send(4'h3);
        check("flush_word", {15'd0, vld, bcd}, {15'd0, 1'b1, 16'h0});
        ack = 1'b1; tick(); ack = 1'b0;

        // Asynchronous reset mid-word and mid-PRESENT
        send(4'h9); send(4'h9);
        #2 rst = 1'b1;
        #1;
        check("arst_collect", {13'd0, err, rdy, vld, bcd}, {13'd0, 3'b010, 16'h0});
        #1 rst = 1'b0;
        #1;
        check("arst_release_ready", {31'd0, rdy}, 32'd1);
        tick();
        send(4'h5); send(4'h6); send(4'h7); send(4'h8);
        check("arst_pre_present", {31'd0, vld}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_present", {13'd0, err, rdy, vld, bcd}, {13'd0, 3'b010, 16'h0});
        #1 rst = 1'b0;
        tick();
        send(4'h7); send(4'h3); send(4'hC); send(4'h4);
        check("arst_new_word", {15'd0, vld, bcd}, {15'd0, 1'b1, 16'h4091});
        ack = 1'b1; tick(); ack = 1'b0;

        // Parameter sweep
        v2 = 1'b1; x2 = 4'h4; tick();
        check("d2_not_yet", {31'd0, vld2}, 32'd0);
        x2 = 4'h5; tick(); v2 = 1'b0;
        check("d2_word", {22'd0, err2, rdy2, vld2, bcd2}, {22'd0, 3'b001, 8'h12});
        for (int i = 0; i < 8; i++) begin
            v8 = 1'b1;
            x8 = 4'(3 + i);
            tick();
            if (i == 6) check("d8_not_yet", {31'd0, vld8}, 32'd0);
        end
        v8 = 1'b0;
        check("d8_word", bcd8, 32'h01234567);
        check("d8_flags", {29'd0, err8, rdy8, vld8}, 32'd1);

        // Randomized run against the reference model
        rst = 1'b1; #1; rst = 1'b0;
        model_reset();
        tick();
        for (int i = 0; i < 1500; i++) begin
            int code;
            v   = ($urandom_range(0, 3) != 0);
            code = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 15))
                                                : int'($urandom_range(3, 12));
            x   = 4'(code);
            ack = ($urandom_range(0, 1) == 1);
            fl  = ($urandom_range(0, 39) == 0);
            tick();
            model_edge(v, code, ack, fl);
            check("rnd_valid", {31'd0, vld}, {31'd0, m_present});
            check("rnd_err", {31'd0, err}, {31'd0, m_err});
            check("rnd_ready", {31'd0, rdy}, {31'd0, !m_err && !m_present});
            if (m_present)
                check("rnd_bcd", {16'd0, bcd}, 32'(m_word));
        end
        v = 0; ack = 0; fl = 0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
